lcd_timing_gen: RTL and testbench

//  Parametrised RGB-LCD timing generator; successor to the fixed 800x480 controller.
//  - Produces HSYNC/VSYNC/DE with per-signal polarity and per-axis porch/sync/active lengths.
//  - Issues pixel requests (x/y) ahead of the pins so a pipelined pixel source of depth RGB_LATENCY lines up exactly.
//  - Adds a built-in colour-bar test pattern, frame/line strobes, and an enable that restarts timing cleanly.

---
 rtl/lcd_timing_gen.sv | 274 +++++++++++++++++++++++++++
 tb/tb_lcd_timing_gen.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: parametrised RGB-LCD timing generator.
//
// Produces HSYNC/VSYNC/DE with programmable polarity and per-axis
// sync/back-porch/active/front-porch lengths. It also issues pixel requests
// (pix_req, x_pos, y_pos) far enough ahead of the pins that a pixel source
// with a fixed pipeline depth of RGB_LATENCY clocks lines up exactly. A
// built-in 8-bar colour pattern can replace the external rgb input.
//
// Ports
//   PixelClk     pixel clock, the only clock
//   nRST         asynchronous active-low reset
//   en           1 = run timing; 0 = counters held at 0, pins inactive
//   pattern_en   1 = drive colour bars instead of rgb (sampled per pixel)
//   rgb          {R[7:0],G[7:0],B[7:0]}, valid RGB_LATENCY clocks after request
//   pix_req      x_pos/y_pos name a visible pixel this cycle
//   x_pos/y_pos  visible column / visible row + Y_OFFSET
//   frame_start  1-cycle pulse with the request of pixel (0,0)
//   line_start   1-cycle pulse with every request at x = 0
//   LCD_*        registered panel timing and colour
//
// Request protocol: pix_req is a one-way strobe with no ready/backpressure.
// The pixel source must accept every request and return its colour on rgb
// exactly RGB_LATENCY clocks later; x_pos/y_pos are only meaningful while
// pix_req is high and hold their last value otherwise.
//
// Pipeline: counters -> stage 1 (requests, sync/DE flags, bar index) ->
// RGB_LATENCY-deep delay line -> pin register. Every pin therefore lags the
// counters by RGB_LATENCY+2 clocks.
module lcd_timing_gen #(
  parameter int H_SYNC      = 1,
  parameter int H_BP        = 182,
  parameter int H_ACTIVE    = 800,
  parameter int H_FP        = 210,
  parameter int V_SYNC      = 5,
  parameter int V_BP        = 0,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 45,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter bit DE_POL      = 1'b1,
  parameter int X_W         = 12,
  parameter int Y_W         = 11,
  parameter int Y_OFFSET    = 56,
  parameter int RGB_LATENCY = 0,
  parameter int R_BITS      = 5,
  parameter int G_BITS      = 6,
  parameter int B_BITS      = 5
) (
  input  logic              PixelClk,
  input  logic              nRST,
  input  logic              en,
  input  logic              pattern_en,
  input  logic [23:0]       rgb,
  output logic              pix_req,
  output logic [X_W-1:0]    x_pos,
  output logic [Y_W-1:0]    y_pos,
  output logic              frame_start,
  output logic              line_start,
  output logic              LCD_HSYNC,
  output logic              LCD_VSYNC,
  output logic              LCD_DE,
  output logic [R_BITS-1:0] LCD_R,
  output logic [G_BITS-1:0] LCD_G,
  output logic [B_BITS-1:0] LCD_B
);

  localparam int H_TOT   = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOT   = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HC_W    = $clog2(H_TOT) + 1;
  localparam int VC_W    = $clog2(V_TOT) + 1;
  localparam int H_START = H_SYNC + H_BP;
  localparam int H_END   = H_START + H_ACTIVE;
  localparam int V_START = V_SYNC + V_BP;
  localparam int V_END   = V_START + V_ACTIVE;
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int BC_W    = $clog2(H_ACTIVE) + 1;

  // Flags that travel together from stage 1 to the pin register.
  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic       pat;
    logic [2:0] bar;
  } pipe_t;

  // ---------------------------------------------------------------------------
  // Counters
  // ---------------------------------------------------------------------------
  logic [HC_W-1:0] h_cnt;
  logic [VC_W-1:0] v_cnt;
  logic            h_last;
  logic            v_last;

  assign h_last = (h_cnt == HC_W'(H_TOT - 1));
  assign v_last = (v_cnt == VC_W'(V_TOT - 1));

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Region decode
  // ---------------------------------------------------------------------------
  logic h_sync, v_sync, h_act, v_act, h_first, v_first;

  assign h_sync  = (h_cnt < HC_W'(H_SYNC));
  assign v_sync  = (v_cnt < VC_W'(V_SYNC));
  assign h_act   = (h_cnt >= HC_W'(H_START)) && (h_cnt < HC_W'(H_END));
  assign v_act   = (v_cnt >= VC_W'(V_START)) && (v_cnt < VC_W'(V_END));
  assign h_first = (h_cnt == HC_W'(H_START));
  assign v_first = (v_cnt == VC_W'(V_START));

  // Coordinate arithmetic is done at the output width so it wraps modulo
  // 2^X_W / 2^Y_W.
  logic [X_W-1:0] x_next;
  logic [Y_W-1:0] y_next;

  assign x_next = X_W'(h_cnt) - X_W'(H_START);
  assign y_next = Y_W'(v_cnt) - Y_W'(V_START) + Y_W'(Y_OFFSET);

  // ---------------------------------------------------------------------------
  // Bar tracking: a run-length counter instead of x / BAR_W. The index stops
  // at 7 so the last bar absorbs the remainder H_ACTIVE - 7*BAR_W.
  // ---------------------------------------------------------------------------
  logic [2:0]      bar_idx, bar_idx_next;
  logic [BC_W-1:0] bar_cnt, bar_cnt_next;

  always_comb begin
    bar_idx_next = bar_idx;
    bar_cnt_next = bar_cnt;
    if (h_first) begin
      bar_idx_next = '0;
      bar_cnt_next = '0;
    end else if (h_act) begin
      if ((bar_cnt == BC_W'(BAR_W - 1)) && (bar_idx != 3'd7)) begin
        bar_idx_next = bar_idx + 3'd1;
        bar_cnt_next = '0;
      end else begin
        bar_cnt_next = bar_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: requests and pipeline flags
  // ---------------------------------------------------------------------------
  pipe_t s1;

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      pix_req     <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      x_pos       <= '0;
      y_pos       <= '0;
      s1          <= '0;
      bar_idx     <= '0;
      bar_cnt     <= '0;
    end else if (!en) begin
      pix_req     <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      x_pos       <= '0;
      y_pos       <= '0;
      s1          <= '0;
      bar_idx     <= '0;
      bar_cnt     <= '0;
    end else begin
      pix_req     <= h_act & v_act;
      frame_start <= h_first & v_first;
      line_start  <= h_first & v_act;
      if (h_act && v_act) begin
        x_pos <= x_next;
        y_pos <= y_next;
      end
      s1.hs   <= h_sync;
      s1.vs   <= v_sync;
      s1.de   <= h_act & v_act;
      s1.pat  <= pattern_en;
      s1.bar  <= bar_idx_next;
      bar_idx <= bar_idx_next;
      bar_cnt <= bar_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Delay line matching the pixel source latency
  // ---------------------------------------------------------------------------
  pipe_t dl_out;

  generate
    if (RGB_LATENCY > 0) begin : g_dl
      pipe_t dl [RGB_LATENCY];

      always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
          for (int i = 0; i < RGB_LATENCY; i++) dl[i] <= '0;
        end else if (!en) begin
          for (int i = 0; i < RGB_LATENCY; i++) dl[i] <= '0;
        end else begin
          dl[0] <= s1;
          for (int i = 1; i < RGB_LATENCY; i++) dl[i] <= dl[i-1];
        end
      end

      assign dl_out = dl[RGB_LATENCY-1];
    end else begin : g_nodl
      assign dl_out = s1;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Pin register
  // ---------------------------------------------------------------------------
  // Bar order white, yellow, cyan, green, magenta, red, blue, black maps to
  // R = ~idx[1], G = ~idx[2], B = ~idx[0].
  logic bar_r, bar_g, bar_b;

  assign bar_r = ~dl_out.bar[1];
  assign bar_g = ~dl_out.bar[2];
  assign bar_b = ~dl_out.bar[0];

  // Low colour bits are dropped when the panel channel is narrower than 8.
  logic unused_rgb;
  assign unused_rgb = ^rgb;

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      LCD_HSYNC <= ~HS_POL;
      LCD_VSYNC <= ~VS_POL;
      LCD_DE    <= ~DE_POL;
      LCD_R     <= '0;
      LCD_G     <= '0;
      LCD_B     <= '0;
    end else if (!en) begin
      LCD_HSYNC <= ~HS_POL;
      LCD_VSYNC <= ~VS_POL;
      LCD_DE    <= ~DE_POL;
      LCD_R     <= '0;
      LCD_G     <= '0;
      LCD_B     <= '0;
    end else begin
      LCD_HSYNC <= dl_out.hs ? HS_POL : ~HS_POL;
      LCD_VSYNC <= dl_out.vs ? VS_POL : ~VS_POL;
      LCD_DE    <= dl_out.de ? DE_POL : ~DE_POL;
      if (!dl_out.de) begin
        LCD_R <= '0;
        LCD_G <= '0;
        LCD_B <= '0;
      end else if (dl_out.pat) begin
        LCD_R <= {R_BITS{bar_r}};
        LCD_G <= {G_BITS{bar_g}};
        LCD_B <= {B_BITS{bar_b}};
      end else begin
        LCD_R <= rgb[23 -: R_BITS];
        LCD_G <= rgb[15 -: G_BITS];
        LCD_B <= rgb[7 -: B_BITS];
      end
    end
  end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen with a small panel geometry so several frames fit
// in a short run. A behavioural model tracks the counter position as a plain
// integer and derives every output from the region arithmetic; a pixel source
// model answers requests with {x, y, 8'hA5} after RGB_LATENCY clocks.
module tb_lcd_timing_gen;

  localparam int H_SYNC = 2, H_BP = 3, H_ACTIVE = 20, H_FP = 4;
  localparam int V_SYNC = 2, V_BP = 1, V_ACTIVE = 4, V_FP = 2;
  localparam bit HS_POL = 1'b0, VS_POL = 1'b1, DE_POL = 1'b1;
  localparam int X_W = 12, Y_W = 6, Y_OFFSET = 62, LAT = 3;
  localparam int R_BITS = 5, G_BITS = 6, B_BITS = 5;

  // Hand-computed geometry
  localparam int H_TOT   = 29;   // 2+3+20+4
  localparam int V_TOT   = 9;    // 2+1+4+2
  localparam int FRAME   = 261;  // 29*9
  localparam int H_START = 5;
  localparam int V_START = 3;
  localparam int BAR_W   = 2;    // 20/8

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic              clk = 1'b0;
  logic              nRST = 1'b0;
  logic              en = 1'b0;
  logic              pattern_en = 1'b0;
  logic [23:0]       rgb = '0;
  logic              pix_req, frame_start, line_start;
  logic [X_W-1:0]    x_pos;
  logic [Y_W-1:0]    y_pos;
  logic              LCD_HSYNC, LCD_VSYNC, LCD_DE;
  logic [R_BITS-1:0] LCD_R;
  logic [G_BITS-1:0] LCD_G;
  logic [B_BITS-1:0] LCD_B;

  always #5 clk = ~clk;

  lcd_timing_gen #(
    .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP),
    .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACTIVE(V_ACTIVE), .V_FP(V_FP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .DE_POL(DE_POL),
    .X_W(X_W), .Y_W(Y_W), .Y_OFFSET(Y_OFFSET), .RGB_LATENCY(LAT),
    .R_BITS(R_BITS), .G_BITS(G_BITS), .B_BITS(B_BITS)
  ) dut (
    .PixelClk(clk), .nRST(nRST), .en(en), .pattern_en(pattern_en), .rgb(rgb),
    .pix_req(pix_req), .x_pos(x_pos), .y_pos(y_pos),
    .frame_start(frame_start), .line_start(line_start),
    .LCD_HSYNC(LCD_HSYNC), .LCD_VSYNC(LCD_VSYNC), .LCD_DE(LCD_DE),
    .LCD_R(LCD_R), .LCD_G(LCD_G), .LCD_B(LCD_B)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard bookkeeping
  // ---------------------------------------------------------------------------
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic bit is_act(input int p);
    int h, v;
    h = p % H_TOT;
    v = p / H_TOT;
    return (h >= H_START) && (h < H_START + H_ACTIVE) &&
           (v >= V_START) && (v < V_START + V_ACTIVE);
  endfunction

  function automatic int pos_x(input int p);
    return (p % H_TOT) - H_START;
  endfunction

  function automatic int pos_y(input int p);
    return ((p / H_TOT) - V_START + Y_OFFSET) % (1 << Y_W);
  endfunction

  // ---------------------------------------------------------------------------
  // Model: per clock edge, the counter position the DUT held before the edge
  // (or -1 when the edge was disabled/reset). hist[0] drives stage 1,
  // hist[LAT+1] drives the pins, provided no edge in between was disabled.
  // ---------------------------------------------------------------------------
  int hist_pos [0:LAT+1] = '{default: -1};
  bit hist_pat [0:LAT+1] = '{default: 1'b0};
  int k = 0;
  int m_x = 0;
  int m_y = 0;

  always @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i <= LAT + 1; i++) hist_pos[i] = -1;
      k = 0; m_x = 0; m_y = 0;
    end else begin
      for (int i = LAT + 1; i > 0; i--) begin
        hist_pos[i] = hist_pos[i-1];
        hist_pat[i] = hist_pat[i-1];
      end
      if (en) begin
        hist_pos[0] = k;
        hist_pat[0] = pattern_en;
        if (is_act(k)) begin
          m_x = pos_x(k);
          m_y = pos_y(k);
        end
        k = (k + 1) % FRAME;
      end else begin
        hist_pos[0] = -1;
        hist_pat[0] = 1'b0;
        k = 0; m_x = 0; m_y = 0;
      end
    end
  end

  // Pixel source: answers the request seen LAT clocks ago.
  int src_x [0:LAT] = '{default: 0};
  int src_y [0:LAT] = '{default: 0};

  always @(negedge clk) begin
    for (int i = LAT; i > 0; i--) begin
      src_x[i] = src_x[i-1];
      src_y[i] = src_y[i-1];
    end
    src_x[0] = int'(x_pos);
    src_y[0] = int'(y_pos);
    rgb = {8'(src_x[LAT]), 8'(src_y[LAT]), 8'hA5};
  end

  // Colour bar table {R,G,B}: white, yellow, cyan, green, magenta, red, blue, black
  logic [2:0] bar_tab [0:7] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                3'b101, 3'b100, 3'b001, 3'b000};

  // ---------------------------------------------------------------------------
  // Compare process plus frame statistics and pattern capture
  // ---------------------------------------------------------------------------
  int meas_gen = 0;
  int armed_gen = -1;
  int frames_checked = 0;
  int c_clk = 0, c_pr = 0, c_de = 0, c_hs = 0, c_vs = 0, c_ls = 0;
  int col = 0;
  int line_len = 0;
  int cap_r [0:H_ACTIVE-1];
  int cap_g [0:H_ACTIVE-1];
  int cap_b [0:H_ACTIVE-1];

  always @(negedge clk) begin
    int p, q, e_hs, e_vs, e_de, er, eg, eb, x, y, b;
    bit ok;
    p = hist_pos[0];
    chk("pix_req", int'(pix_req), (p >= 0 && is_act(p)) ? 1 : 0);
    chk("frame_start", int'(frame_start),
        (p >= 0 && p == V_START * H_TOT + H_START) ? 1 : 0);
    chk("line_start", int'(line_start),
        (p >= 0 && is_act(p) && (p % H_TOT) == H_START) ? 1 : 0);
    chk("x_pos", int'(x_pos), m_x);
    chk("y_pos", int'(y_pos), m_y);

    ok = 1'b1;
    for (int i = 0; i <= LAT + 1; i++) if (hist_pos[i] < 0) ok = 1'b0;
    q = hist_pos[LAT+1];
    e_hs = (ok && (q % H_TOT) < H_SYNC) ? 1 : 0;
    e_vs = (ok && (q / H_TOT) < V_SYNC) ? 1 : 0;
    e_de = (ok && is_act(q)) ? 1 : 0;
    er = 0; eg = 0; eb = 0;
    if (e_de == 1) begin
      x = pos_x(q);
      y = pos_y(q);
      if (hist_pat[LAT+1]) begin
        b = x / BAR_W;
        if (b > 7) b = 7;
        er = bar_tab[b][2] ? 31 : 0;
        eg = bar_tab[b][1] ? 63 : 0;
        eb = bar_tab[b][0] ? 31 : 0;
      end else begin
        er = (x & 255) >> 3;
        eg = (y & 255) >> 2;
        eb = 8'hA5 >> 3;
      end
    end
    chk("LCD_HSYNC", int'(LCD_HSYNC), (e_hs == 1) ? int'(HS_POL) : int'(!HS_POL));
    chk("LCD_VSYNC", int'(LCD_VSYNC), (e_vs == 1) ? int'(VS_POL) : int'(!VS_POL));
    chk("LCD_DE", int'(LCD_DE), (e_de == 1) ? int'(DE_POL) : int'(!DE_POL));
    chk("LCD_R", int'(LCD_R), er);
    chk("LCD_G", int'(LCD_G), eg);
    chk("LCD_B", int'(LCD_B), eb);

    // Per-frame statistics between consecutive frame_start pulses.
    if (frame_start) begin
      chk("fs_x_pos", int'(x_pos), 0);
      chk("fs_y_pos", int'(y_pos), 62);
      if (armed_gen == meas_gen) begin
        chk("frame_clks", c_clk, 261);
        chk("frame_pix_req", c_pr, 80);
        chk("frame_de", c_de, 80);
        chk("frame_hsync", c_hs, 18);
        chk("frame_vsync", c_vs, 58);
        chk("frame_line_start", c_ls, 4);
        frames_checked++;
      end
      armed_gen = meas_gen;
      c_clk = 0; c_pr = 0; c_de = 0; c_hs = 0; c_vs = 0; c_ls = 0;
    end
    c_clk++;
    if (pix_req) c_pr++;
    if (line_start) c_ls++;
    if (LCD_DE == DE_POL) c_de++;
    if (LCD_HSYNC == HS_POL) c_hs++;
    if (LCD_VSYNC == VS_POL) c_vs++;

    // Capture pin colour by column of the most recent DE line.
    if (LCD_DE == DE_POL) begin
      if (col < H_ACTIVE) begin
        cap_r[col] = int'(LCD_R);
        cap_g[col] = int'(LCD_G);
        cap_b[col] = int'(LCD_B);
      end
      col++;
    end else begin
      if (col != 0) line_len = col;
      col = 0;
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int cnt, fc0;
    bit found;

    repeat (3) @(negedge clk);
    chk("rst_hsync", int'(LCD_HSYNC), 1);
    chk("rst_vsync", int'(LCD_VSYNC), 0);
    chk("rst_de", int'(LCD_DE), 0);
    chk("rst_pix_req", int'(pix_req), 0);
    en = 1'b1;
    @(negedge clk);
    nRST = 1'b1;

    // Free-running frames with the external pixel source.
    repeat (3 * FRAME + 10) @(negedge clk);

    // Colour bars over a whole frame, then inspect one captured line.
    pattern_en = 1'b1;
    repeat (2 * FRAME) @(negedge clk);
    chk("bar_line_len", line_len, 20);
    chk("bar0_r", cap_r[0], 31);
    chk("bar0_g", cap_g[0], 63);
    chk("bar0_b", cap_b[0], 31);
    chk("bar1_b_x2", cap_b[2], 0);
    chk("bar5_r_x11", cap_r[11], 31);
    chk("bar5_g_x11", cap_g[11], 0);
    chk("bar6_b_x13", cap_b[13], 31);
    chk("bar6_r_x13", cap_r[13], 0);
    chk("bar7_b_x14", cap_b[14], 0);
    chk("last_r", cap_r[19], 0);
    chk("last_g", cap_g[19], 0);
    chk("last_b", cap_b[19], 0);

    // pattern_en switching mid-line.
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (i % 7 == 0) pattern_en = ~pattern_en;
    end
    pattern_en = 1'b0;

    // Asynchronous reset in the middle of an active line.
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (pix_req && x_pos == 7) begin
        found = 1'b1;
        break;
      end
    end
    chk("found_mid_line", int'(found), 1);
    meas_gen++;
    #2 nRST = 1'b0;
    #1;
    chk("arst_hsync", int'(LCD_HSYNC), 1);
    chk("arst_vsync", int'(LCD_VSYNC), 0);
    chk("arst_de", int'(LCD_DE), 0);
    chk("arst_r", int'(LCD_R), 0);
    chk("arst_pix_req", int'(pix_req), 0);
    chk("arst_x_pos", int'(x_pos), 0);
    repeat (3) @(negedge clk);
    nRST = 1'b1;
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      cnt++;
      if (LCD_DE == DE_POL) break;
    end
    chk("first_de_after_reset", cnt, 97);

    // en low for 1000 clocks mid-frame.
    repeat (100) @(negedge clk);
    meas_gen++;
    en = 1'b0;
    repeat (1000) @(negedge clk);
    chk("en_low_hsync", int'(LCD_HSYNC), 1);
    chk("en_low_de", int'(LCD_DE), 0);
    en = 1'b1;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      cnt++;
      if (LCD_HSYNC == HS_POL) break;
    end
    chk("hsync_after_en", cnt, 5);
    fc0 = frames_checked;
    repeat (3 * FRAME) @(negedge clk);
    chk("frames_after_en", (frames_checked - fc0 >= 2) ? 1 : 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
